// File: rtl/intdiv_sched.sv
// ---------------------------------------------------------------------------
// intdiv_sched
//
// Purpose:
//   Shares one external pipelined signed divider among REQS requesters. Each
//   cycle one requester is picked round-robin and its operands are issued.
//   A tag pipeline tracks every operation in flight. Results land in a
//   credit-protected FIFO and return in issue order on one tagged response
//   channel. Divide-by-zero and the signed overflow case (-2^(N-1) / -1) are
//   detected at issue and patched when the result is written.
//
// Ports:
//   clock, reset   clock and synchronous active-high reset
//   req_valid      per-requester request valid            [REQS]
//   req_ready      per-requester accept (combinational)   [REQS]
//   req_x, req_y   packed operands, requester k at [k*N +: N]
//   div_x, div_y   registered operands to the divider (div_y never zero)
//   div_z, div_r   divider quotient / remainder, LAT cycles after issue
//   res_valid      response valid (FIFO not empty)
//   res_ready      response accept
//   res_id         originating requester
//   res_z, res_r   quotient (truncating) and remainder (sign of dividend)
//   res_dbz        divide-by-zero flag
//   res_ovf        signed overflow flag
//   busy           any operation in flight or any buffered result
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. req_ready depends combinationally on req_valid, the
// round-robin pointer and the credit state; a requester holds valid and its
// operands stable until it sees ready. res_valid/res_* come straight from the
// FIFO head and stay stable until accepted with res_ready.
// ---------------------------------------------------------------------------
module intdiv_sched #(
    parameter int N     = 16,
    parameter int REQS  = 2,
    parameter int LAT   = 4,
    parameter int DEPTH = 8,
    parameter int IDW   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REQS-1:0]     req_valid,
    output logic [REQS-1:0]     req_ready,
    input  logic [REQS*N-1:0]   req_x,
    input  logic [REQS*N-1:0]   req_y,
    output logic [N-1:0]        div_x,
    output logic [N-1:0]        div_y,
    input  logic [N-1:0]        div_z,
    input  logic [N-1:0]        div_r,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDW-1:0]      res_id,
    output logic [N-1:0]        res_z,
    output logic [N-1:0]        res_r,
    output logic                res_dbz,
    output logic                res_ovf,
    output logic                busy
);

    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough to hold FIFO count + in-flight count + one pending pop.
    localparam int CW     = $clog2(DEPTH + LAT + 2) + 1;
    localparam int STAGES = LAT + 1;

    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           dbz;
        logic           ovf;
        logic [N-1:0]   x;
    } tag_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N-1:0]   z;
        logic [N-1:0]   r;
        logic           dbz;
        logic           ovf;
    } res_t;

    // Round-robin candidate k positions after base, wrapped into 0..REQS-1.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        int i;
        i = int'(base) + k;
        if (i >= REQS) begin
            i = i - REQS;
        end
        return IDW'(i);
    endfunction

    function automatic logic [AW-1:0] fifo_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [IDW-1:0] rr_ptr;
    tag_t           tag_q [STAGES];
    res_t           fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_count;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic [CW-1:0]  inflight;
    logic           credit_ok;
    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic [N-1:0]   grant_x;
    logic [N-1:0]   grant_y;
    logic           grant_dbz;
    logic           grant_ovf;
    logic           push;
    logic           pop;
    res_t           push_data;
    res_t           head;

    // Count of valid tags across every stage, including the issue register.
    always_comb begin
        inflight = '0;
        for (int s = 0; s < STAGES; s++) begin
            inflight = inflight + CW'(tag_q[s].valid);
        end
    end

    assign res_valid = (fifo_count != '0);
    assign pop       = res_valid && res_ready;

    // An issue must have a guaranteed FIFO slot when its result exits the
    // divider, because the divider cannot be stalled. Occupancy counts both
    // buffered results and every tag in flight; a pop this cycle frees one.
    assign credit_ok = (fifo_count + inflight) < (CW'(DEPTH) + CW'(pop));

    // Round-robin arbitration: first valid requester at or after rr_ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        for (int k = 0; k < REQS; k++) begin
            if (!grant_any && req_valid[rr_index(rr_ptr, k)]) begin
                grant_any = 1'b1;
                grant_idx = rr_index(rr_ptr, k);
            end
        end
        // Nothing is accepted while in reset or when out of credit.
        if (reset || !credit_ok) begin
            grant_any = 1'b0;
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        grant_x = '0;
        grant_y = '0;
        for (int k = 0; k < REQS; k++) begin
            if (int'(grant_idx) == k) begin
                grant_x = req_x[k*N +: N];
                grant_y = req_y[k*N +: N];
            end
        end
    end

    assign grant_dbz = (grant_y == '0);
    assign grant_ovf = (grant_x == MOST_NEG) && (grant_y == '1);

    // -----------------------------------------------------------------------
    // Issue register, tag pipeline and round-robin pointer
    // -----------------------------------------------------------------------
    // tag_q[0] is the issue register and lines up with div_x/div_y; each
    // later stage follows one divider stage, so tag_q[LAT] is valid in the
    // same cycle its div_z/div_r appear.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                tag_q[s] <= '0;
            end
            div_x  <= '0;
            div_y  <= N'(1);
            rr_ptr <= '0;
        end else begin
            if (grant_any) begin
                tag_q[0] <= '{valid: 1'b1, id: grant_idx, dbz: grant_dbz,
                              ovf: grant_ovf, x: grant_x};
                div_x    <= grant_x;
                // A zero divisor is replaced by 1 so the divider never sees
                // it; the real result is substituted on the way out.
                div_y    <= grant_dbz ? N'(1) : grant_y;
                rr_ptr   <= (int'(grant_idx) == REQS - 1) ? '0 : grant_idx + 1'b1;
            end else begin
                tag_q[0] <= '0;
                div_x    <= '0;
                div_y    <= N'(1);
            end
            for (int s = 1; s < STAGES; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Result patching on tag exit
    // -----------------------------------------------------------------------
    always_comb begin
        push           = tag_q[LAT].valid;
        push_data.id   = tag_q[LAT].id;
        push_data.dbz  = tag_q[LAT].dbz;
        push_data.ovf  = tag_q[LAT].ovf;
        push_data.z    = div_z;
        push_data.r    = div_r;
        if (tag_q[LAT].dbz) begin
            push_data.z = '1;
            push_data.r = tag_q[LAT].x;
        end else if (tag_q[LAT].ovf) begin
            // -2^(N-1) / -1 wraps back to -2^(N-1) with no remainder.
            push_data.z = tag_q[LAT].x;
            push_data.r = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Result FIFO
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= fifo_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= fifo_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Response outputs: head of FIFO, forced to zero while empty
    // -----------------------------------------------------------------------
    assign head    = fifo_mem[rd_ptr];
    assign res_id  = res_valid ? head.id  : '0;
    assign res_z   = res_valid ? head.z   : '0;
    assign res_r   = res_valid ? head.r   : '0;
    assign res_dbz = res_valid ? head.dbz : 1'b0;
    assign res_ovf = res_valid ? head.ovf : 1'b0;

    assign busy = res_valid || (inflight != '0);

endmodule

// File: tb/tb_intdiv_sched.sv
// ---------------------------------------------------------------------------
// tb_intdiv_sched
//
// Bench for intdiv_sched. Contains a behavioural LAT-cycle signed divider,
// a scoreboard fed at every grant from an independent reference model, a
// table of hand-computed single-operation vectors, and directed sequences
// for back-to-back issue, fairness, back-pressure and mid-flight reset.
// ---------------------------------------------------------------------------
module tb_intdiv_sched;

    localparam int N     = 16;
    localparam int REQS  = 2;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int IDW   = 1;
    localparam int RW    = IDW + 2*N + 2;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [REQS-1:0]     req_valid = '0;
    logic [REQS-1:0]     req_ready;
    logic [REQS*N-1:0]   req_x = '0;
    logic [REQS*N-1:0]   req_y = '0;
    logic [N-1:0]        div_x;
    logic [N-1:0]        div_y;
    logic [N-1:0]        div_z;
    logic [N-1:0]        div_r;
    logic                res_valid;
    logic                res_ready = 1'b1;
    logic [IDW-1:0]      res_id;
    logic [N-1:0]        res_z;
    logic [N-1:0]        res_r;
    logic                res_dbz;
    logic                res_ovf;
    logic                busy;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    intdiv_sched #(.N(N), .REQS(REQS), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_z     (div_z),
        .div_r     (div_r),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_z     (res_z),
        .res_r     (res_r),
        .res_dbz   (res_dbz),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    // -----------------------------------------------------------------------
    // Behavioural divider: samples div_x/div_y at a clock edge, result is
    // visible LAT cycles after the cycle in which the operands were driven.
    // -----------------------------------------------------------------------
    logic [N-1:0] pz [LAT];
    logic [N-1:0] pr [LAT];
    int dm_a;
    int dm_b;

    always @(posedge clock) begin
        dm_a = int'($signed(div_x));
        dm_b = int'($signed(div_y));
        if (dm_b == 0) begin
            pz[0] <= '0;
            pr[0] <= '0;
        end else begin
            pz[0] <= 16'(dm_a / dm_b);
            pr[0] <= 16'(dm_a % dm_b);
        end
        for (int i = 1; i < LAT; i++) begin
            pz[i] <= pz[i-1];
            pr[i] <= pr[i-1];
        end
    end

    assign div_z = pz[LAT-1];
    assign div_r = pr[LAT-1];

    // -----------------------------------------------------------------------
    // Checking helpers and scoreboard
    // -----------------------------------------------------------------------
    int tests = 0;
    int fails = 0;

    logic [RW-1:0] exp_q[$];
    int            grant_log[$];
    int            grant_cyc_log[$];
    int            resp_id_log[$];
    int            resp_cyc_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result for one request, as the response channel should show it.
    function automatic logic [RW-1:0] model(input logic [IDW-1:0] id, input logic [N-1:0] x,
                                            input logic [N-1:0] y);
        logic [N-1:0] z;
        logic [N-1:0] r;
        logic         dbz;
        logic         ovf;
        int           a;
        int           b;
        a   = int'($signed(x));
        b   = int'($signed(y));
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 0) begin
            dbz = 1'b1;
            z   = 16'hFFFF;
            r   = x;
        end else if (x == 16'h8000 && y == 16'hFFFF) begin
            ovf = 1'b1;
            z   = 16'h8000;
            r   = 16'h0000;
        end else begin
            z = 16'(a / b);
            r = 16'(a % b);
        end
        return {id, z, r, dbz, ovf};
    endfunction

    logic [RW-1:0] sb_exp;

    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < REQS; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    grant_log.push_back(k);
                    grant_cyc_log.push_back(cyc);
                    exp_q.push_back(model(IDW'(k), req_x[k*N +: N], req_y[k*N +: N]));
                end
            end
            if (req_ready != '0) begin
                check("ready_onehot", 64'($countones(req_ready)), 64'd1);
            end
            if (res_valid && res_ready) begin
                resp_id_log.push_back(int'(res_id));
                resp_cyc_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got id=%0d z=0x%0h, expected no response",
                             res_id, res_z);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("scoreboard", 64'({res_id, res_z, res_r, res_dbz, res_ovf}), 64'(sb_exp));
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic set_req(input int k, input logic [N-1:0] x, input logic [N-1:0] y);
        req_x[k*N +: N] = x;
        req_y[k*N +: N] = y;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        grant_cyc_log.delete();
        resp_id_log.delete();
        resp_cyc_log.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("idle", 64'(busy), 64'd0);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus table
    // -----------------------------------------------------------------------
    typedef struct {
        int           k;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] ez;
        logic [N-1:0] er;
        logic         edbz;
        logic         eovf;
    } vec_t;

    vec_t         vecs [10];
    logic [N-1:0] b2b_x [3];
    logic [N-1:0] b2b_y [3];

    initial begin
        bit got;
        int n;
        int lat;
        int g;

        //               k   x         y         z         r         dbz   ovf
        vecs[0] = '{0, 16'd7,    16'd3,    16'd2,    16'd1,    1'b0, 1'b0};
        vecs[1] = '{1, 16'hFFF3, 16'd4,    16'hFFFD, 16'hFFFF, 1'b0, 1'b0};
        vecs[2] = '{0, 16'd13,   16'hFFFC, 16'hFFFD, 16'd1,    1'b0, 1'b0};
        vecs[3] = '{1, 16'hFF88, 16'd11,   16'hFFF6, 16'hFFF6, 1'b0, 1'b0};
        vecs[4] = '{0, 16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1, 1'b0};
        vecs[5] = '{1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{0, 16'h8000, 16'd1,    16'h8000, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{1, 16'h7FFF, 16'hFFFF, 16'h8001, 16'h0000, 1'b0, 1'b0};
        vecs[8] = '{0, 16'd0,    16'd0,    16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[9] = '{1, 16'd100,  16'd100,  16'd1,    16'd0,    1'b0, 1'b0};

        b2b_x[0] = 16'hFFF3; b2b_y[0] = 16'd4;
        b2b_x[1] = 16'd13;   b2b_y[1] = 16'hFFFC;
        b2b_x[2] = 16'hFF88; b2b_y[2] = 16'd11;

        // ---- Reset state (requests held valid to show they are ignored) ----
        reset     = 1'b1;
        req_valid = '1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_fields", 64'({res_id, res_z, res_r, res_dbz, res_ovf}), 64'd0);
        check("rst_div_x", 64'(div_x), 64'd0);
        check("rst_div_y", 64'(div_y), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        req_valid = '0;
        reset     = 1'b0;

        // ---- Table: single operations, latency and patched results ----
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            set_req(vecs[i].k, vecs[i].x, vecs[i].y);
            req_valid[vecs[i].k] = 1'b1;
            got = 1'b0;
            n   = 0;
            while (!got && n < 20) begin
                @(negedge clock);
                n++;
                if (req_ready[vecs[i].k]) got = 1'b1;
            end
            check($sformatf("v%0d_grant", i), 64'(got), 64'd1);
            @(posedge clock);
            #1;
            req_valid[vecs[i].k] = 1'b0;
            @(negedge clock);
            check($sformatf("v%0d_div_x", i), 64'(div_x), 64'(vecs[i].x));
            check($sformatf("v%0d_div_y", i), 64'(div_y),
                  (vecs[i].y == 16'd0) ? 64'd1 : 64'(vecs[i].y));
            lat = 1;
            while (!res_valid && lat < 30) begin
                @(negedge clock);
                lat++;
            end
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT + 2));
            check($sformatf("v%0d_id", i), 64'(res_id), 64'(vecs[i].k));
            check($sformatf("v%0d_z", i), 64'(res_z), 64'(vecs[i].ez));
            check($sformatf("v%0d_r", i), 64'(res_r), 64'(vecs[i].er));
            check($sformatf("v%0d_dbz", i), 64'(res_dbz), 64'(vecs[i].edbz));
            check($sformatf("v%0d_ovf", i), 64'(res_ovf), 64'(vecs[i].eovf));
            wait_idle();
        end

        // ---- Back-to-back signed ops from requester 1 ----
        clear_logs();
        @(posedge clock);
        #1;
        set_req(1, b2b_x[0], b2b_y[0]);
        req_valid[1] = 1'b1;
        g = 0;
        n = 0;
        while (g < 3 && n < 30) begin
            @(negedge clock);
            n++;
            if (req_ready[1]) begin
                g++;
                @(posedge clock);
                #1;
                if (g < 3) set_req(1, b2b_x[g], b2b_y[g]);
                else req_valid[1] = 1'b0;
            end
        end
        wait_idle();
        check("b2b_grants", 64'(grant_cyc_log.size()), 64'd3);
        check("b2b_resps", 64'(resp_cyc_log.size()), 64'd3);
        if (grant_cyc_log.size() == 3 && resp_cyc_log.size() == 3) begin
            for (int i = 1; i < 3; i++) begin
                check("b2b_grant_gap", 64'(grant_cyc_log[i] - grant_cyc_log[i-1]), 64'd1);
                check("b2b_resp_gap", 64'(resp_cyc_log[i] - resp_cyc_log[i-1]), 64'd1);
                check("b2b_resp_id", 64'(resp_id_log[i]), 64'd1);
            end
        end

        // ---- Fairness: both requesters valid for 8 cycles ----
        clear_logs();
        @(posedge clock);
        #1;
        set_req(0, 16'd20, 16'd3);
        set_req(1, 16'hFFEC, 16'd3);
        req_valid = '1;
        repeat (8) @(negedge clock);
        @(posedge clock);
        #1;
        req_valid = '0;
        wait_idle();
        check("fair_grants", 64'(grant_log.size()), 64'd8);
        check("fair_resps", 64'(resp_id_log.size()), 64'd8);
        if (grant_log.size() == 8 && resp_id_log.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                check("fair_grant_alt", 64'(grant_log[i] != grant_log[i-1]), 64'd1);
                check("fair_resp_alt", 64'(resp_id_log[i] != resp_id_log[i-1]), 64'd1);
            end
        end

        // ---- Back-pressure: exactly DEPTH grants, then drain ----
        clear_logs();
        @(posedge clock);
        #1;
        res_ready = 1'b0;
        set_req(0, 16'd100, 16'd7);
        set_req(1, 16'hFFCE, 16'd3);
        req_valid = '1;
        repeat (30) @(negedge clock);
        check("bp_grants", 64'(grant_log.size()), 64'(DEPTH));
        check("bp_ready_low", 64'(req_ready), 64'd0);
        check("bp_res_valid", 64'(res_valid), 64'd1);
        check("bp_busy", 64'(busy), 64'd1);
        @(posedge clock);
        #1;
        req_valid = '0;
        res_ready = 1'b1;
        wait_idle();
        check("bp_drained", 64'(resp_id_log.size()), 64'(DEPTH));
        check("bp_exp_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
        set_req(1, 16'd9, 16'd2);
        req_valid[1] = 1'b1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            if (req_ready[1]) got = 1'b1;
        end
        check("bp_resume_grant", 64'(got), 64'd1);
        @(posedge clock);
        #1;
        req_valid = '0;
        wait_idle();

        // ---- Reset mid-flight: three ops from req0, then one reset cycle ----
        clear_logs();
        @(posedge clock);
        #1;
        set_req(0, 16'd50, 16'd7);
        set_req(1, 16'd60, 16'd7);
        req_valid[0] = 1'b1;
        g = 0;
        n = 0;
        while (g < 3 && n < 30) begin
            @(negedge clock);
            n++;
            if (req_ready[0]) g++;
        end
        check("rst_mid_grants", 64'(g), 64'd3);
        @(posedge clock);
        #1;
        req_valid = '0;
        reset     = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (12) @(negedge clock);
        check("rst_mid_no_resp", 64'(resp_id_log.size()), 64'd0);
        check("rst_mid_res_valid", 64'(res_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        req_valid = '1;
        @(negedge clock);
        check("rst_mid_first_grant", 64'(req_ready), 64'b01);
        @(posedge clock);
        #1;
        req_valid = '0;
        wait_idle();
        check("final_exp_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit in case a bounded wait is bypassed by a broken design.
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
